i_keys_debounce4: RTL and testbench

- Upstream stage of the inverted 4-to-2 encoder.
- Takes 2**SIZE raw, bouncing, active-low push-button lines and synchronises and debounces each line.
- Emits a clean active-low one-hot vector `key_n` only while exactly one key is held. Otherwise all lines read released.
- `key_n` drives the encoder's `a` input directly; `press_stb` and `key_valid` qualify the encoded `b`.

---
 rtl/i_keys_pkg.sv | 33 +++
 rtl/i_keys_debounce4_line.sv | 52 +++++
 rtl/i_keys_debounce4.sv | 129 ++++++++++++
 tb/tb_i_keys_debounce4.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_keys_pkg.sv
// i_keys_pkg
// Shared definitions for the key debouncer front end of the inverted 4-to-2
// encoder:
//   - default parameter values
//   - the FSM state encoding
//   - a zero-count helper used to classify the debounced key vector
package i_keys_pkg;

  localparam int SIZE_DEF     = 2;
  localparam int DEBOUNCE_DEF = 4;
  localparam int CNT_W_DEF    = 16;

  // Widest key vector the zero-count helper handles.
  localparam int MAX_KEYS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LOCK  = 2'd2
  } state_t;

  // Number of zero bits (pressed keys) in v.
  // Callers pad unused upper bits with ones so that those bits are not counted.
  function automatic int unsigned zero_count(input logic [MAX_KEYS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (!v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/i_keys_debounce4_line.sv
// i_debounce_line
// One raw active-low button line:
//   - two-flop synchroniser
//   - per-line debounce counter
//   - stable level flop
// A new synchronised level is accepted only after it has differed from the
// stable level on DEBOUNCE consecutive comparisons. Any return to the stable
// level restarts the count.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   raw_n    raw, asynchronous button line (0 = pressed)
//   stable_n debounced level (0 = pressed)
module i_debounce_line
  import i_keys_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic stable_n
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable_n <= 1'b1;
      cnt      <= '0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      if (sync2 == stable_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable_n <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i_keys_debounce4.sv
// i_keys_debounce4
// Debounces 2**SIZE active-low push buttons and presents a clean one-hot
// active-low key vector to the downstream encoder. The vector is presented
// only while exactly one key is held; more than one key locks the output
// released until every key has been let go.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   keys_raw_n raw button lines (0 = pressed)
//   key_n      debounced one-hot active-low key, all ones when none is valid
//   key_valid  high while exactly one key is held and not locked
//   press_stb  one-cycle pulse when key_valid rises
//   multi_err  high while locked after a multi-key press
//
// state | meaning
// IDLE  | no key held, outputs released
// PRESS | exactly one key held, key_n presents it
// LOCK  | more than one key was seen, wait for full release
module i_keys_debounce4
  import i_keys_pkg::*;
#(
  parameter int SIZE     = SIZE_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2**SIZE-1:0]   keys_raw_n,
  output logic [2**SIZE-1:0]   key_n,
  output logic                 key_valid,
  output logic                 press_stb,
  output logic                 multi_err
);

  localparam int NKEYS = 2**SIZE;

  logic [NKEYS-1:0] stable_n;

  for (genvar g = 0; g < NKEYS; g++) begin : g_line
    i_debounce_line #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
    ) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_n    (keys_raw_n[g]),
      .stable_n (stable_n[g])
    );
  end

  state_t               state_q;
  state_t               state_d;
  logic [NKEYS-1:0]     key_n_d;
  logic                 key_valid_d;
  logic                 press_stb_d;
  logic                 multi_err_d;
  logic [MAX_KEYS-1:0]  stable_ext;
  int unsigned          zeros;

  always_comb begin
    stable_ext              = '1;
    stable_ext[NKEYS-1:0]   = stable_n;
    zeros                   = zero_count(stable_ext);
  end

  always_comb begin
    state_d     = state_q;
    key_n_d     = key_n;
    key_valid_d = key_valid;
    press_stb_d = 1'b0;
    multi_err_d = multi_err;
    case (state_q)
      IDLE: begin
        if (zeros == 1) begin
          state_d     = PRESS;
          key_n_d     = stable_n;
          key_valid_d = 1'b1;
          press_stb_d = 1'b1;
        end else if (zeros >= 2) begin
          state_d     = LOCK;
          multi_err_d = 1'b1;
        end
      end
      PRESS: begin
        if (zeros == 0) begin
          state_d     = IDLE;
          key_n_d     = '1;
          key_valid_d = 1'b0;
        end else if (zeros >= 2 || stable_n != key_n) begin
          // A different single key counts as a second press: the first
          // key was never observed released.
          state_d     = LOCK;
          key_n_d     = '1;
          key_valid_d = 1'b0;
          multi_err_d = 1'b1;
        end
      end
      LOCK: begin
        if (zeros == 0) begin
          state_d     = IDLE;
          multi_err_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        key_n_d     = '1;
        key_valid_d = 1'b0;
        multi_err_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      key_n     <= '1;
      key_valid <= 1'b0;
      press_stb <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_n     <= key_n_d;
      key_valid <= key_valid_d;
      press_stb <= press_stb_d;
      multi_err <= multi_err_d;
    end
  end

endmodule

// File: tb/tb_i_keys_debounce4.sv
// tb_i_keys_debounce4
// Directed scenarios followed by randomised key patterns. Every cycle the DUT
// outputs are compared against a behavioural model that works from the
// history of raw samples taken at each clock edge.
module tb_i_keys_debounce4;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] keys_raw_n = 4'b0000;
  logic [3:0] key_n;
  logic       key_valid;
  logic       press_stb;
  logic       multi_err;

  i_keys_debounce4 #(.SIZE(2), .DEBOUNCE(D), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys_raw_n (keys_raw_n),
    .key_n      (key_n),
    .key_valid  (key_valid),
    .press_stb  (press_stb),
    .multi_err  (multi_err)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int stb_count = 0;

  // Model state
  logic [3:0] hist[$];      // raw vector sampled at each edge since reset
  int         edge_no;
  int         last_acc[4];
  logic [3:0] m_stable;
  logic [3:0] m_key_n;
  logic       m_valid;
  logic       m_stb;
  logic       m_err;
  int         m_mode;       // 0 idle, 1 single key shown, 2 locked

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    edge_no = 0;
    for (int i = 0; i < 4; i++) last_acc[i] = -1000;
    m_stable = 4'hF;
    m_key_n  = 4'hF;
    m_valid  = 1'b0;
    m_stb    = 1'b0;
    m_err    = 1'b0;
    m_mode   = 0;
  endtask

  // Raw sample of line i taken at edge k; before the first edge the
  // synchroniser holds the released level.
  function automatic logic sample_at(input int k, input int i);
    logic [3:0] v;
    if (k < 0) return 1'b1;
    v = hist[k];
    return v[i];
  endfunction

  task automatic model_edge();
    logic [3:0] nxt;
    int         z;
    bit         all_diff;
    hist.push_back(keys_raw_n);
    z = $countones(~m_stable);
    m_stb = 1'b0;
    case (m_mode)
      0: begin
        if (z == 1) begin
          m_mode = 1; m_key_n = m_stable; m_valid = 1'b1; m_stb = 1'b1;
        end else if (z >= 2) begin
          m_mode = 2; m_err = 1'b1;
        end
      end
      1: begin
        if (z == 0) begin
          m_mode = 0; m_key_n = 4'hF; m_valid = 1'b0;
        end else if (z >= 2 || m_stable != m_key_n) begin
          m_mode = 2; m_key_n = 4'hF; m_valid = 1'b0; m_err = 1'b1;
        end
      end
      default: begin
        if (z == 0) begin
          m_mode = 0; m_err = 1'b0;
        end
      end
    endcase
    // A level is accepted when the D most recent synchronised samples (two
    // edges of synchroniser delay) all differ from the stable level and none
    // of them was already consumed by an earlier acceptance.
    nxt = m_stable;
    for (int i = 0; i < 4; i++) begin
      if (edge_no - last_acc[i] >= D) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (sample_at(edge_no - 2 - j, i) == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          nxt[i] = ~m_stable[i];
          last_acc[i] = edge_no;
        end
      end
    end
    m_stable = nxt;
    edge_no++;
  endtask

  task automatic check_model();
    chk("key_n", {28'd0, key_n}, {28'd0, m_key_n});
    chk("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
    chk("press_stb", {31'd0, press_stb}, {31'd0, m_stb});
    chk("multi_err", {31'd0, multi_err}, {31'd0, m_err});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_key_n"}, {28'd0, key_n}, 32'hF);
    chk({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
    chk({tag, "_stb"}, {31'd0, press_stb}, 32'd0);
    chk({tag, "_err"}, {31'd0, multi_err}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (press_stb === 1'b1) stb_count++;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called at posedge+1: assert reset between edges and check that outputs
  // clear before any clock edge, then release after the following edge.
  task automatic async_reset(input string tag);
    #4;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_vals(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] enc_b(input logic [3:0] kn);
    logic [1:0] b;
    b = 2'd0;
    for (int i = 0; i < 4; i++) if (!kn[i]) b = 2'(i);
    return b;
  endfunction

  initial begin
    logic [3:0] pat;
    int         hold;

    // 1. Reset held with all keys pressed
    model_reset();
    keys_raw_n = 4'b0000;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_reset_vals("rst_hold");
    end
    keys_raw_n = 4'b1111;
    rst_n = 1'b1;
    steps(4);

    // 2. Clean press of line 2
    keys_raw_n = 4'b1011;
    steps(6);
    chk("press_early", {28'd0, key_n}, 32'hF);
    step();
    chk("press_key_n", {28'd0, key_n}, 32'hB);
    chk("press_valid", {31'd0, key_valid}, 32'd1);
    chk("press_stb", {31'd0, press_stb}, 32'd1);
    chk("press_enc_b", {30'd0, enc_b(key_n)}, 32'd2);
    step();
    chk("press_stb_one", {31'd0, press_stb}, 32'd0);
    keys_raw_n = 4'b1111;
    steps(6);
    chk("release_early", {31'd0, key_valid}, 32'd1);
    step();
    chk("release_key_n", {28'd0, key_n}, 32'hF);
    chk("release_valid", {31'd0, key_valid}, 32'd0);
    steps(3);

    // 3. Bouncing line 0, then settle pressed
    stb_count = 0;
    for (int i = 0; i < 10; i++) begin
      keys_raw_n = {3'b111, (i % 2 == 1)};
      steps(2);
      chk("bounce_key_n", {28'd0, key_n}, 32'hF);
    end
    keys_raw_n = 4'b1110;
    steps(6);
    chk("settle_early", {28'd0, key_n}, 32'hF);
    step();
    chk("settle_key_n", {28'd0, key_n}, 32'hE);
    steps(4);
    chk("bounce_stb_count", stb_count, 32'd1);
    keys_raw_n = 4'b1111;
    steps(8);

    // 4. Glitch of DEBOUNCE-1 cycles on line 3
    stb_count = 0;
    keys_raw_n = 4'b0111;
    steps(D - 1);
    keys_raw_n = 4'b1111;
    steps(10);
    chk("glitch_key_n", {28'd0, key_n}, 32'hF);
    chk("glitch_stb_count", stb_count, 32'd0);

    // 5. Second key while first is held
    keys_raw_n = 4'b1101;
    steps(8);
    chk("two_first_valid", {31'd0, key_valid}, 32'd1);
    keys_raw_n = 4'b1001;
    steps(8);
    chk("two_lock_err", {31'd0, multi_err}, 32'd1);
    chk("two_lock_key_n", {28'd0, key_n}, 32'hF);
    chk("two_lock_valid", {31'd0, key_valid}, 32'd0);
    keys_raw_n = 4'b1101;
    steps(8);
    chk("two_partial_err", {31'd0, multi_err}, 32'd1);
    chk("two_partial_valid", {31'd0, key_valid}, 32'd0);
    keys_raw_n = 4'b1111;
    steps(8);
    chk("two_release_err", {31'd0, multi_err}, 32'd0);

    // 6. Two keys accepted on the same edge
    stb_count = 0;
    keys_raw_n = 4'b0110;
    steps(8);
    chk("simul_err", {31'd0, multi_err}, 32'd1);
    chk("simul_stb_count", stb_count, 32'd0);
    keys_raw_n = 4'b1111;
    steps(8);

    // Asynchronous reset during a held press and during a count
    keys_raw_n = 4'b1110;
    steps(8);
    chk("pre_reset_valid", {31'd0, key_valid}, 32'd1);
    async_reset("async_press");
    steps(3);
    async_reset("async_count");
    steps(10);
    keys_raw_n = 4'b1111;
    steps(10);

    // Randomised patterns and hold times, with occasional resets
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0:       pat = 4'hF;
        1:       pat = ~(4'b0001 << $urandom_range(0, 3));
        default: pat = 4'($urandom_range(0, 15));
      endcase
      keys_raw_n = pat;
      hold = $urandom_range(1, 9);
      steps(hold);
      if ($urandom_range(0, 49) == 0) async_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
